// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared USB transmit definitions: PID codes, the transmit
//               arbiter state encoding and the PID-byte helper.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    // Token-less PIDs used by the transmit arbiter (4-bit codes).
    localparam logic [3:0] c_PID_ACK   = 4'b0010;
    localparam logic [3:0] c_PID_NAK   = 4'b1010;
    localparam logic [3:0] c_PID_STALL = 4'b1110;
    localparam logic [3:0] c_PID_DATA0 = 4'b0011;
    localparam logic [3:0] c_PID_DATA1 = 4'b1011;

    // Transmit arbiter states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_PID   = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5
    } arb_state_t;

    // On the wire a PID byte carries the check nibble (inverted PID) on top.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage : usb_pkg
`default_nettype wire

// File: rtl/usb_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_cycle_timer
// Description : Saturating up-counter. Reset and load clear it; enable
//               advances it; expired is high on the LIMIT-th enabled cycle
//               and stays high until the next load.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_cycle_timer #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int             c_WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(LIMIT - 1);

    logic [c_WIDTH-1:0] r_count;

    assign expired = (r_count == c_LAST);

    // Count enabled cycles, holding at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : usb_cycle_timer
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_arbiter
// Description : Arbitrates the ULPI transmit path between a handshake source
//               (fixed priority) and a data-packet source, framing each
//               transfer with start/stop pulses and enforcing an inter-packet
//               gap. Optional build macro USB_TX_ARB_TIMEOUT_EN adds an abort
//               when the transmit path stalls for TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_arbiter
    import usb_pkg::*;
#(
    parameter int IPG_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       USB_CLKIN,
    input  logic       NRST,
    input  logic       rx_busy,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    output logic       hs_done,
    output logic       hs_fail,
    input  logic       pkt_req,
    input  logic [3:0] pkt_pid,
    input  logic       pkt_zlp,
    input  logic [7:0] pkt_data,
    input  logic       pkt_last,
    output logic       pkt_strb,
    output logic       pkt_done,
    output logic       pkt_fail,
    output logic [7:0] tx_data,
    output logic       tx_start_stop,
    input  logic       tx_strb,
    input  logic       tx_fail
);

    if (IPG_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("usb_tx_arbiter: IPG_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic       r_owner_hs;
    logic [3:0] r_pid;
    logic       r_zlp;

    logic w_active;
    logic w_grant;
    logic w_gap_load;
    logic w_gap_enable;
    logic w_gap_expired;
    logic w_timeout;

    assign w_active = (r_state == ST_PID) || (r_state == ST_DATA);

    // The gap timer runs in IDLE as well, so the first grant after reset
    // also waits a full inter-packet gap. Receive activity restarts it.
    assign w_gap_enable = (r_state == ST_IDLE) || (r_state == ST_GAP);
    assign w_gap_load   = !w_gap_enable || rx_busy;

    assign w_grant = (r_state == ST_IDLE) && !rx_busy && w_gap_expired
                   && (hs_req || pkt_req);

    usb_cycle_timer #(
        .LIMIT   (IPG_CYCLES)
    ) u_gap_timer (
        .clk     (USB_CLKIN),
        .rst_n   (NRST),
        .load    (w_gap_load),
        .enable  (w_gap_enable),
        .expired (w_gap_expired)
    );

`ifdef USB_TX_ARB_TIMEOUT_EN
    logic w_to_expired;

    // Counts consecutive PID/DATA cycles without a transmit strobe.
    usb_cycle_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout_timer (
        .clk     (USB_CLKIN),
        .rst_n   (NRST),
        .load    (!w_active || tx_strb),
        .enable  (w_active),
        .expired (w_to_expired)
    );

    assign w_timeout = w_active && !tx_strb && w_to_expired;
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winning requester at grant; later request changes are ignored.
    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            r_owner_hs <= 1'b0;
            r_pid      <= 4'd0;
            r_zlp      <= 1'b0;
        end else if (w_grant) begin
            r_owner_hs <= hs_req;
            r_pid      <= hs_req ? hs_pid : pkt_pid;
            r_zlp      <= hs_req ? 1'b0 : pkt_zlp;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_next_state = ST_PID;
            end
            ST_PID: begin
                if (tx_fail || w_timeout) begin
                    w_next_state = ST_GAP;
                end else if (tx_strb) begin
                    w_next_state = (r_owner_hs || r_zlp) ? ST_STOP : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_fail || w_timeout) begin
                    w_next_state = ST_GAP;
                end else if (tx_strb && pkt_last) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_expired && !rx_busy) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode; every output is zero in IDLE, hence zero during reset.
    always_comb begin
        tx_data       = 8'd0;
        tx_start_stop = 1'b0;
        hs_done       = 1'b0;
        hs_fail       = 1'b0;
        pkt_strb      = 1'b0;
        pkt_done      = 1'b0;
        pkt_fail      = 1'b0;
        case (r_state)
            ST_START: begin
                tx_data       = pid_byte(r_pid);
                tx_start_stop = 1'b1;
            end
            ST_PID, ST_DATA: begin
                tx_data       = (r_state == ST_PID) ? pid_byte(r_pid) : pkt_data;
                // A transmit-path abort suppresses the stop pulse; a timeout
                // still closes the frame.
                tx_start_stop = w_timeout && !tx_fail;
                hs_fail       = r_owner_hs && (tx_fail || w_timeout);
                pkt_fail      = !r_owner_hs && (tx_fail || w_timeout);
                pkt_strb      = (r_state == ST_DATA) && tx_strb && !tx_fail;
            end
            ST_STOP: begin
                tx_start_stop = 1'b1;
                hs_done       = r_owner_hs;
                pkt_done      = !r_owner_hs;
            end
            default: begin
                tx_data = 8'd0;
            end
        endcase
    end

endmodule : usb_tx_arbiter
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_arbiter
// Description : Directed self-checking bench for usb_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_arbiter;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       NRST;
    logic       rx_busy, hs_req, pkt_req, pkt_zlp, pkt_last, tx_strb, tx_fail;
    logic [3:0] hs_pid, pkt_pid;
    logic [7:0] pkt_data;
    logic       hs_done, hs_fail, pkt_strb, pkt_done, pkt_fail, tx_start_stop;
    logic [7:0] tx_data;

    int n_checks   = 0;
    int n_failures = 0;
    int n_start    = 0;
    int n_done     = 0;
    int n_fail     = 0;
    int n_pkt_strb = 0;
    int s0, d0, f0, n;

    usb_tx_arbiter #(
        .IPG_CYCLES     (8),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .USB_CLKIN     (clk),
        .NRST          (NRST),
        .rx_busy       (rx_busy),
        .hs_req        (hs_req),
        .hs_pid        (hs_pid),
        .hs_done       (hs_done),
        .hs_fail       (hs_fail),
        .pkt_req       (pkt_req),
        .pkt_pid       (pkt_pid),
        .pkt_zlp       (pkt_zlp),
        .pkt_data      (pkt_data),
        .pkt_last      (pkt_last),
        .pkt_strb      (pkt_strb),
        .pkt_done      (pkt_done),
        .pkt_fail      (pkt_fail),
        .tx_data       (tx_data),
        .tx_start_stop (tx_start_stop),
        .tx_strb       (tx_strb),
        .tx_fail       (tx_fail)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled on the active edge.
    always @(posedge clk) begin
        n_start    <= n_start + int'(tx_start_stop);
        n_done     <= n_done + int'(hs_done | pkt_done);
        n_fail     <= n_fail + int'(hs_fail | pkt_fail);
        n_pkt_strb <= n_pkt_strb + int'(pkt_strb);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Wait for the start pulse; checks latency (cycles from the call) and PID byte.
    task automatic expect_start(input string tag, input int exp_wait, input logic [7:0] exp_byte);
        int k;
        k = 0;
        do begin
            cyc();
            tx_strb = 1'b0;
            tx_fail = 1'b0;
            #1;
            k++;
        end while (!tx_start_stop && k < 40);
        chk({tag, "_wait"}, k, exp_wait);
        chk({tag, "_byte"}, tx_data, exp_byte);
    endtask

    task automatic pid_phase(input string tag, input logic [7:0] exp_byte);
        cyc();
        tx_strb = 1'b1;
        #1;
        chk({tag, "_pid_data"}, tx_data, exp_byte);
        chk({tag, "_pid_nostop"}, {tx_start_stop, pkt_strb}, 2'b00);
    endtask

    task automatic stop_phase(input string tag, input logic exp_hs, input logic exp_pkt);
        cyc();
        tx_strb  = 1'b0;
        pkt_last = 1'b0;
        #1;
        chk({tag, "_stop"}, {tx_start_stop, hs_done, pkt_done, hs_fail, pkt_fail},
            {1'b1, exp_hs, exp_pkt, 2'b00});
        chk({tag, "_stop_data"}, tx_data, 8'h00);
    endtask

    initial begin
        NRST = 1'b0; rx_busy = 1'b0; hs_req = 1'b0; pkt_req = 1'b0; pkt_zlp = 1'b0;
        pkt_last = 1'b0; tx_strb = 1'b1; tx_fail = 1'b0;
        hs_pid = 4'd0; pkt_pid = 4'd0; pkt_data = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outs", {tx_data, tx_start_stop, hs_done, hs_fail, pkt_strb, pkt_done, pkt_fail}, 0);

        // Handshake ACK right out of reset: first grant only after the gap.
        tx_strb = 1'b0;
        hs_req  = 1'b1;
        hs_pid  = c_PID_ACK;
        NRST    = 1'b1;
        expect_start("first_grant", 8, 8'hD2);
        pid_phase("ack", 8'hD2);
        stop_phase("ack", 1'b1, 1'b0);

        // Back-to-back handshake must wait the inter-packet gap.
        hs_pid = c_PID_NAK;
        expect_start("ipg_gap", 10, 8'h5A);
        pid_phase("nak", 8'h5A);
        stop_phase("nak", 1'b1, 1'b0);

        // Simultaneous requests: handshake wins, packet follows after the gap.
        hs_pid  = c_PID_STALL;
        pkt_req = 1'b1;
        pkt_pid = c_PID_DATA0;
        expect_start("prio_hs", 10, 8'h1E);
        pid_phase("stall", 8'h1E);
        stop_phase("stall", 1'b1, 1'b0);
        hs_req = 1'b0;

        // Four-byte DATA0 packet, strobe every cycle.
        expect_start("pkt_after_gap", 10, 8'hC3);
        s0 = n_pkt_strb;
        pid_phase("pkt4", 8'hC3);
        for (int b = 1; b <= 4; b++) begin
            cyc();
            pkt_data = 8'(b);
            pkt_last = (b == 4);
            tx_strb  = 1'b1;
            #1;
            chk("pkt4_byte", tx_data, 32'(b));
            chk("pkt4_strb", pkt_strb, 1'b1);
        end
        stop_phase("pkt4", 1'b0, 1'b1);
        chk("pkt4_strb_count", n_pkt_strb - s0, 4);

        // Transmit-path abort during byte 2.
        expect_start("pkt_fail", 10, 8'hC3);
        pid_phase("pktf", 8'hC3);
        cyc();
        pkt_data = 8'h11;
        tx_strb  = 1'b1;
        #1;
        chk("pktf_b1_strb", pkt_strb, 1'b1);
        cyc();
        pkt_data = 8'h22;
        tx_strb  = 1'b0;
        tx_fail  = 1'b1;
        #1;
        chk("pktf_abort", {pkt_fail, tx_start_stop, pkt_strb, pkt_done}, 4'b1000);
        pkt_req = 1'b0;
        hs_req  = 1'b1;
        hs_pid  = c_PID_ACK;
        expect_start("fail_gap", 10, 8'hD2);
        pid_phase("ack2", 8'hD2);
        stop_phase("ack2", 1'b1, 1'b0);

        // Zero-length DATA1; request dropped after grant.
        hs_req  = 1'b0;
        pkt_req = 1'b1;
        pkt_pid = c_PID_DATA1;
        pkt_zlp = 1'b1;
        expect_start("zlp", 10, 8'h4B);
        pkt_req = 1'b0;
        pkt_zlp = 1'b0;
        s0 = n_pkt_strb;
        pid_phase("zlp", 8'h4B);
        stop_phase("zlp", 1'b0, 1'b1);
        chk("zlp_no_strb", n_pkt_strb - s0, 0);

        // Receive activity mid-gap restarts the gap count.
        hs_req = 1'b1;
        hs_pid = c_PID_NAK;
        repeat (3) cyc();
        rx_busy = 1'b1;
        repeat (3) cyc();
        rx_busy = 1'b0;
        expect_start("rx_reload", 9, 8'h5A);
        hs_req = 1'b0;
        cyc();
        rx_busy = 1'b1;
        tx_strb = 1'b1;
        #1;
        chk("rx_mid_pid", tx_data, 8'h5A);
        stop_phase("rx_mid", 1'b1, 1'b0);
        rx_busy = 1'b0;

        // Request withdrawn before grant; strobes while idle are ignored.
        pkt_req = 1'b1;
        pkt_pid = c_PID_DATA0;
        repeat (2) cyc();
        pkt_req = 1'b0;
        tx_strb = 1'b1;
        s0 = n_start;
        d0 = n_pkt_strb;
        repeat (15) cyc();
        tx_strb = 1'b0;
        chk("drop_before_grant", n_start - s0, 0);
        chk("idle_strb_ignored", n_pkt_strb - d0, 0);

        // Reset asserted in the middle of DATA.
        pkt_req = 1'b1;
        expect_start("pkt3", 1, 8'hC3);
        pkt_req = 1'b0;
        pid_phase("pkt3", 8'hC3);
        cyc();
        pkt_data = 8'hA5;
        tx_strb  = 1'b1;
        #1;
        chk("pkt3_data", {tx_data, pkt_strb}, {8'hA5, 1'b1});
        d0 = n_done;
        f0 = n_fail;
        s0 = n_start;
        NRST = 1'b0;
        #1;
        chk("mid_reset_outs", {tx_data, tx_start_stop, hs_done, hs_fail, pkt_strb, pkt_done, pkt_fail}, 0);
        repeat (2) cyc();
        chk("held_reset_outs", {tx_data, tx_start_stop, hs_done, hs_fail, pkt_strb, pkt_done, pkt_fail}, 0);
        tx_strb = 1'b0;
        NRST    = 1'b1;
        repeat (12) cyc();
        chk("reset_no_done_fail", {n_done - d0, n_fail - f0}, 0);
        chk("reset_no_stop", n_start - s0, 0);

`ifdef USB_TX_ARB_TIMEOUT_EN
        // Transmit path never strobes in DATA: abort with stop at cycle 1024.
        pkt_req = 1'b1;
        expect_start("pkt_to", 1, 8'hC3);
        pkt_req = 1'b0;
        pid_phase("pkt_to", 8'hC3);
        n = 0;
        do begin
            cyc();
            tx_strb = 1'b0;
            #1;
            n++;
        end while (!tx_start_stop && n < 1100);
        chk("timeout_cycles", n, 1024);
        chk("timeout_fail", {pkt_fail, pkt_done}, 2'b10);
        repeat (12) cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule : tb_usb_tx_arbiter
`default_nettype wire

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
- REQ-001 SHALL use one clock and an asynchronous, active-low reset.
- REQ-002 SHALL have parameter IPG_CYCLES, default 8: idle cycles enforced after every transmit or receive.
- REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum wait for tx_strb before abort.
- REQ-004 SHALL have ports:
  - USB_CLKIN  in  1  60 MHz ULPI clock.
  - NRST  in  1  asynchronous active-low reset.
  - rx_busy  in  1  receive path active; no grant while high.
  - hs_req  in  1  handshake request; level, held until done or fail.
  - hs_pid  in  4  handshake PID (ACK/NAK/STALL).
  - hs_done  out  1  one-cycle pulse: handshake sent.
  - hs_fail  out  1  one-cycle pulse: handshake aborted.
  - pkt_req  in  1  data-packet request; level.
  - pkt_pid  in  4  data PID (DATA0/DATA1).
  - pkt_zlp  in  1  zero-length packet; sampled at grant.
  - pkt_data  in  8  current payload byte.
  - pkt_last  in  1  pkt_data is the final byte.
  - pkt_strb  out  1  pulse: pkt_data consumed; present next byte.
  - pkt_done  out  1  pulse: packet sent.
  - pkt_fail  out  1  pulse: packet aborted.
  - tx_data  out  8  byte to ULPI transmit path.
  - tx_start_stop  out  1  one-cycle start/stop pulse to transmit path.
  - tx_strb  in  1  transmit path consumed tx_data.
  - tx_fail  in  1  transmit path aborted.

Function
- REQ-005 SHALL implement states IDLE, START, PID, DATA, STOP and GAP.
- REQ-006 IDLE: when rx_busy=0, SHALL grant hs_req over pkt_req (fixed priority), latch the PID and the owner, and go to START.
- REQ-007 START: SHALL drive tx_data={~pid,pid} and tx_start_stop=1 for exactly one cycle, then go to PID.
- REQ-008 PID: on tx_strb, SHALL go to STOP if the owner is handshake or pkt_zlp was latched, else go to DATA.
- REQ-009 DATA: SHALL drive tx_data=pkt_data combinationally.
- REQ-010 DATA: each tx_strb SHALL produce a pkt_strb pulse in the same cycle.
- REQ-011 DATA: tx_strb with pkt_last=1 SHALL go to STOP.
- REQ-012 STOP: SHALL pulse tx_start_stop=1 for one cycle and pulse the owner's done, then go to GAP.
- REQ-013 GAP: SHALL count IPG_CYCLES cycles, then go to IDLE. The counter SHALL reload while rx_busy=1.
- REQ-014 tx_fail in PID or DATA SHALL pulse the owner's fail, go to GAP, and not assert tx_start_stop.
- REQ-015 tx_data SHALL be 0 in IDLE and GAP.
- REQ-016 A request that drops before grant SHALL be ignored.
- REQ-017 A request that drops after grant SHALL NOT cancel the transfer.
- REQ-018 rx_busy rising while a transfer is active SHALL NOT abort it.
- REQ-019 tx_strb in IDLE, START, STOP or GAP SHALL be ignored.

Reset
- REQ-020 NRST=0 SHALL force IDLE, clear the counters and drive every output to 0.
- REQ-021 Reset asserted mid-transfer SHALL NOT emit done, fail or a stop pulse.
- REQ-022 After reset release, the first grant SHALL NOT occur before IPG_CYCLES cycles.

Configuration
- REQ-023 With USB_TX_ARB_TIMEOUT_EN defined: in PID or DATA, TIMEOUT_CYCLES consecutive cycles without tx_strb SHALL pulse tx_start_stop and the owner's fail, then go to GAP.
- REQ-024 Without USB_TX_ARB_TIMEOUT_EN: the arbiter SHALL wait indefinitely and no timeout logic SHALL be synthesized.

Structure
- REQ-025 PID constants and the state enum SHALL live in shared package usb_pkg.
- REQ-026 The gap and timeout counters SHALL be instances of sub-module usb_cycle_timer (load, enable, expired).

Verification
- REQ-027 hs_req=1, hs_pid=ACK(0010), tx_strb one cycle after start -> tx_data=8'hD2 with start pulse, stop pulse, hs_done pulse; a further grant no earlier than 8 cycles later.
- REQ-028 pkt_req with DATA0 and 4 bytes 01..04, tx_strb every cycle -> bytes in order, 4 pkt_strb pulses, stop pulse and pkt_done after byte 04.
- REQ-029 hs_req and pkt_req raised in the same cycle -> handshake sent first; packet starts after the gap.
- REQ-030 tx_fail during byte 2 of a packet -> pkt_fail pulse, no stop pulse, state returns to IDLE after 8 cycles.
- REQ-031 pkt_zlp=1 with DATA1 -> tx_data=8'h4B, then stop; zero pkt_strb pulses.
- REQ-032 With the timeout macro defined, tx_strb held 0 -> stop pulse and fail pulse at cycle 1024; NRST pulsed mid-DATA -> all outputs 0, no done or fail.
